// File: rtl/s3g_packet_tx_if.sv
// s3g_packet_tx_if: payload-buffer, start/status and UART byte handshake bundle for the S3G reply framer.
interface s3g_packet_tx_if #(parameter int ADDR_W = 5) ();
  logic              buf_wr;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic [7:0]        payload_len;
  logic              packet_wr;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done;
  logic              busy;
  logic              packet_sent;
  logic              len_err;
  logic              timeout;
  modport master (output buf_wr, buf_addr, buf_data, payload_len, packet_wr, tx_done,
                  input tx_data, tx_wr, busy, packet_sent, len_err, timeout);
  modport slave (input buf_wr, buf_addr, buf_data, payload_len, packet_wr, tx_done,
                 output tx_data, tx_wr, busy, packet_sent, len_err, timeout);
endinterface

// File: rtl/s3g_packet_tx.sv
// s3g_packet_tx: frames the buffered payload as D5, len, payload, CRC8 (Maxim) one UART byte at a time.
// Define S3G_TX_TIMEOUT_EN to abort a packet when tx_done stalls for TIMEOUT_CYCLES.
module s3g_packet_tx #(
  parameter int MAX_PAYLOAD    = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic          clk,
  input logic          rst,
  s3g_packet_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  if (MAX_PAYLOAD > 2**ADDR_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("s3g_packet_tx: invalid MAX_PAYLOAD/ADDR_W/TIMEOUT_CYCLES");
  end

  state_t     state_q, state_d;
  logic [8:0] idx_q, idx_d;
  logic [7:0] len_q, len_d, crc_q, crc_d, tx_data_q, tx_data_d, rd_q;
  logic       tx_wr_q, tx_wr_d, busy_q, busy_d, sent_q, sent_d, len_err_q, len_err_d;
  logic [7:0] mem [MAX_PAYLOAD];
  logic [8:0] nxt, crc_pos;
  logic       last, nxt_crc;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    return c;
  endfunction

  // idx_q is the byte currently on the wire; the read address targets the payload byte after it
  always_ff @(posedge clk) begin
    if (bus.buf_wr && !busy_q) mem[bus.buf_addr] <= bus.buf_data;
    rd_q <= mem[ADDR_W'(idx_q - 9'd1)];
  end

  assign nxt     = idx_q + 9'd1;
  assign crc_pos = {1'b0, len_q} + 9'd2;
  assign last    = idx_q == crc_pos;
  assign nxt_crc = nxt == crc_pos;

`ifdef S3G_TX_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        timeout_q, timeout_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == WAIT && !bus.tx_done) ? cnt_q + 32'd1 : '0;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    crc_d     = crc_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    busy_d    = busy_q;
    sent_d    = 1'b0;
    len_err_d = 1'b0;
`ifdef S3G_TX_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (bus.packet_wr) begin
        if (bus.payload_len > 8'(MAX_PAYLOAD)) len_err_d = 1'b1;
        else begin
          state_d   = SEND;
          len_d     = bus.payload_len;
          crc_d     = 8'h00;
          idx_d     = '0;
          tx_wr_d   = 1'b1;
          tx_data_d = 8'hD5;
          busy_d    = 1'b1;
        end
      end
      SEND: state_d = WAIT;
      WAIT: if (bus.tx_done) begin
        if (last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          sent_d  = 1'b1;
        end else begin
          state_d   = SEND;
          idx_d     = nxt;
          tx_wr_d   = 1'b1;
          tx_data_d = (nxt == 9'd1) ? len_q : nxt_crc ? crc_q : rd_q;
          crc_d     = (nxt != 9'd1 && !nxt_crc) ? crc8(crc_q, rd_q) : crc_q;
        end
      end
`ifdef S3G_TX_TIMEOUT_EN
      else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        timeout_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      crc_q     <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      crc_q     <= crc_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
      len_err_q <= len_err_d;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_wr       = tx_wr_q;
  assign bus.busy        = busy_q;
  assign bus.packet_sent = sent_q;
  assign bus.len_err     = len_err_q;
endmodule

// File: tb/tb_s3g_packet_tx.sv
// tb_s3g_packet_tx: directed and randomized packets checked against a byte-queue framing model with bit-serial CRC8.
module tb_s3g_packet_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] pay [32];

  s3g_packet_tx_if #(.ADDR_W(5)) ifc ();
  s3g_packet_tx dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_ref(input int len);
    logic [7:0] c = 8'h00;
    for (int k = 0; k < len; k++)
      for (int b = 0; b < 8; b++) begin
        logic fb = c[0] ^ pay[k][b];
        c = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    return c;
  endfunction

  task automatic load(input int len);
    for (int i = 0; i < len; i++) begin
      ifc.buf_wr = 1'b1;
      ifc.buf_addr = 5'(i);
      ifc.buf_data = pay[i];
      tick;
    end
    ifc.buf_wr = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit disturb);
    logic [7:0] exp [$];
    exp = {};
    exp.push_back(8'hD5);
    exp.push_back(8'(len));
    for (int i = 0; i < len; i++) exp.push_back(pay[i]);
    exp.push_back(crc_ref(len));
    ifc.payload_len = 8'(len);
    ifc.packet_wr = 1'b1;
    tick;
    ifc.packet_wr = 1'b0;
    foreach (exp[k]) begin
      chk("tx_wr", ifc.tx_wr, 1);
      chk($sformatf("tx_data[%0d]", k), ifc.tx_data, exp[k]);
      chk("busy", ifc.busy, 1);
      chk("sent_early", ifc.packet_sent, 0);
      tick;
      chk("tx_wr_pulse", ifc.tx_wr, 0);
      if (disturb && k == 0) begin
        ifc.packet_wr = 1'b1;
        ifc.payload_len = 8'd2;
        ifc.buf_wr = 1'b1;
        ifc.buf_addr = 5'd0;
        ifc.buf_data = ~pay[0];
        tick;
        ifc.packet_wr = 1'b0;
        ifc.buf_wr = 1'b0;
        chk("tx_wr_disturb", ifc.tx_wr, 0);
      end
      repeat ($urandom_range(0, 3)) begin
        tick;
        chk("tx_wr_wait", ifc.tx_wr, 0);
      end
      ifc.tx_done = 1'b1;
      tick;
      ifc.tx_done = 1'b0;
    end
    chk("packet_sent", ifc.packet_sent, 1);
    chk("busy_end", ifc.busy, 0);
    chk("tx_wr_end", ifc.tx_wr, 0);
    repeat (3) begin
      tick;
      chk("no_extra", {ifc.packet_sent, ifc.tx_wr, ifc.busy}, 0);
    end
  endtask

  initial begin
    ifc.buf_wr = 1'b0;
    ifc.buf_addr = '0;
    ifc.buf_data = '0;
    ifc.payload_len = '0;
    ifc.packet_wr = 1'b0;
    ifc.tx_done = 1'b0;
    #12;
    chk("reset_outs", {ifc.tx_data, ifc.tx_wr, ifc.busy, ifc.packet_sent, ifc.len_err, ifc.timeout}, 0);
    tick;
    rst = 1'b1;
    tick;
    // single-byte payload, CRC of 0x81 is D2
    pay[0] = 8'h81;
    load(1);
    send_pkt(1, 0);
    pay[0] = 8'h81; pay[1] = 8'hBA; pay[2] = 8'hCE;
    load(3);
    send_pkt(3, 0);
    send_pkt(0, 0);
    // oversize length is rejected
    ifc.payload_len = 8'd33;
    ifc.packet_wr = 1'b1;
    tick;
    ifc.packet_wr = 1'b0;
    chk("len_err", ifc.len_err, 1);
    chk("len_err_tx_wr", ifc.tx_wr, 0);
    chk("len_err_busy", ifc.busy, 0);
    tick;
    chk("len_err_pulse", ifc.len_err, 0);
    chk("len_err_idle", {ifc.tx_wr, ifc.busy}, 0);
    // disturbance during transmission
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    load(4);
    send_pkt(4, 1);
    // reset while waiting on the len byte
    pay[0] = 8'h81;
    load(1);
    ifc.payload_len = 8'd1;
    ifc.packet_wr = 1'b1;
    tick;
    ifc.packet_wr = 1'b0;
    tick;
    ifc.tx_done = 1'b1;
    tick;
    ifc.tx_done = 1'b0;
    chk("pre_rst_len", {ifc.tx_wr, ifc.tx_data}, 9'h101);
    tick;
    rst = 1'b0;
    #1;
    chk("abort_outs", {ifc.tx_data, ifc.tx_wr, ifc.busy, ifc.packet_sent, ifc.len_err, ifc.timeout}, 0);
    tick;
    rst = 1'b1;
    tick;
    ifc.tx_done = 1'b1;
    tick;
    ifc.tx_done = 1'b0;
    repeat (2) begin
      tick;
      chk("late_done", {ifc.tx_wr, ifc.busy, ifc.packet_sent}, 0);
    end
    pay[0] = 8'h81;
    load(1);
    send_pkt(1, 0);
    // randomized lengths including the 32-byte maximum
    for (int r = 0; r < 6; r++) begin
      int len = (r == 0) ? 32 : int'($urandom_range(0, 32));
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      load(len);
      send_pkt(len, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/s3g_packet_tx.md
Name: s3g_packet_tx

Overview:
- S3G reply framer: the transmit-side counterpart of s3g_rx. Holds a reply payload in an internal byte buffer and sends it as one S3G packet: 0xD5, length, payload bytes, CRC8.
- Sits between command-handling logic and uart_transceiver. Drives tx_data/tx_wr and consumes tx_done, one byte at a time.

Parameters:
- MAX_PAYLOAD, 32, payload buffer depth in bytes (S3G max); must be ≤ 2**ADDR_W.
- ADDR_W, 5, buffer address width.
- TIMEOUT_CYCLES, 1000000, tx_done watchdog limit in clk cycles; used only with S3G_TX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (osc_clk domain)
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- buf_wr  in  1  payload buffer write strobe
- buf_addr  in  ADDR_W  payload buffer write address
- buf_data  in  8  payload byte to write
- payload_len  in  8  payload length, sampled on packet_wr
- packet_wr  in  1  single-cycle start request
- tx_data  out  8  byte to UART transmitter
- tx_wr  out  1  single-cycle UART write strobe
- tx_done  in  1  UART byte-complete pulse
- busy  out  1  packet in progress
- packet_sent  out  1  single-cycle pulse, packet complete
- len_err  out  1  single-cycle pulse, packet_wr rejected because payload_len > MAX_PAYLOAD
- timeout  out  1  single-cycle pulse, aborted by watchdog (tied 0 without macro)

Behaviour:
- Reset (rst=0, async): state=IDLE; tx_data=0, tx_wr=0, busy=0, packet_sent=0, len_err=0, timeout=0; CRC=0; byte index=0. The buffer RAM is not reset and its contents are unspecified.
- Buffer writes are accepted only when busy=0. buf_wr while busy=1 is ignored, so the payload is stable during transmission.
- States: IDLE, SEND, WAIT.
- IDLE:
  - On packet_wr with payload_len ≤ MAX_PAYLOAD: latch the length, clear CRC and index, busy=1, go to SEND.
  - On packet_wr with payload_len > MAX_PAYLOAD: pulse len_err for one cycle and stay in IDLE.
  - tx_done is ignored in IDLE.
- SEND: drive tx_data with the current byte and pulse tx_wr for exactly 1 cycle, then go to WAIT. Byte sequence is 0xD5, len, buf[0..len-1], CRC.
- WAIT: on tx_done, advance to the next byte and return to SEND. After the CRC byte's tx_done, pulse packet_sent, set busy=0 and go to IDLE.
- Latency:
  - packet_wr at cycle N gives tx_wr with 0xD5 at cycle N+1.
  - tx_done at cycle M gives the next tx_wr at M+1, or packet_sent at M+1 after the CRC byte.
- tx_wr is never asserted twice without an intervening tx_done.
- packet_wr while busy=1 is ignored; no queueing and no error.
- payload_len=0: send D5, 00, CRC=00 (3 bytes).
- CRC8 (Maxim/iButton):
  - Computed over payload bytes only; init 0x00.
  - Per bit: if (crc^bit) LSB is set, crc=(crc>>1)^0x8C, else crc>>=1. Processed LSB first.
  - Updated combinationally, 8 bits per byte, when each payload byte is issued.
- Buffer read is synchronous. The read address is presented one cycle before SEND of a payload byte, so there is no extra bubble.
- Reset during a packet: immediate abort, tx_wr=0. A byte already handed to the UART completes on the wire; the resulting tx_done arrives in IDLE and is ignored.

Optional Feature:
- Macro S3G_TX_TIMEOUT_EN.
- Defined: a counter runs in WAIT and clears on every tx_done. On reaching TIMEOUT_CYCLES, the block aborts the packet: pulse timeout, busy=0, go to IDLE, no packet_sent.
- Undefined: no counter, timeout tied 0, WAIT lasts indefinitely.

Test Plan:
- Write buf[0]=0x81, packet_wr with len=1 → tx_wr bytes D5, 01, 81, D2; each tx_wr exactly 1 cycle after the previous tx_done; packet_sent 1 cycle after the 4th tx_done; busy high throughout.
- Write buf[0..2]=81,BA,CE, packet_wr with len=3 → 6 bytes D5, 03, 81, BA, CE, CRC. CRC must equal the reference model value (bit-serial 0x8C model in the bench).
- packet_wr with len=0 → D5, 00, 00 then packet_sent. With len=33 → len_err pulse, no tx_wr, busy stays 0.
- During transmission: second packet_wr and buf_wr to addr 0 → both ignored; payload bytes on the wire unchanged; only one packet_sent.
- Assert rst low while in WAIT after the len byte → all outputs 0 immediately; late tx_done ignored; next packet_wr with len=1, buf[0]=0x81 sends D5, 01, 81, D2 cleanly.
- With S3G_TX_TIMEOUT_EN, TIMEOUT_CYCLES=100: withhold tx_done after the first byte → timeout pulse exactly 100 cycles into WAIT, busy=0, no packet_sent.
